// File: rtl/ps2_pkg.sv
// ps2_pkg: constants shared by the PS/2 receiver and the downstream scan-code decoder.
//   PS2_FRAME_BITS : bits per PS/2 frame (start, 8 data, parity, stop)
//   SC_BREAK       : break (key release) prefix byte
//   SC_EXT         : extended-key prefix byte
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: scan-code handshake between the PS/2 receiver and its consumer.
//   nextdata_n : active-low pop request from the consumer
//   data       : FIFO head byte, valid while ready=1
//   ready      : FIFO non-empty
//   overflow   : sticky, a valid byte was dropped on a full FIFO
//   frame_err  : one-cycle pulse per malformed frame
// master = receiver side, slave = consumer side.
interface ps2_keyboard_rx_if;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        input  nextdata_n,
        output data, ready, overflow, frame_err
    );

    modport slave (
        output nextdata_n,
        input  data, ready, overflow, frame_err
    );
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: 8-bit synchronous scan-code FIFO with occupancy counter.
//   clock50   : clock, rising edge
//   clrn      : synchronous active-low reset (clears pointers, occupancy, storage, overflow)
//   push      : write push_data this cycle
//   push_data : byte to queue
//   pop       : advance the read pointer (ignored when empty)
//   head      : byte at the read pointer
//   ready     : FIFO non-empty
//   overflow  : sticky, set when a push is dropped
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock50,
    input  logic       clrn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       ready,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign pop_ok = pop && (cnt != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock50) begin
        if (!clrn) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push_ok) begin
                mem[w_ptr] <= push_data;
                w_ptr      <= w_ptr + 1'b1;
            end
            if (pop_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head  = mem[r_ptr];
    assign ready = (cnt != '0);
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver. Synchronises the PS/2 clock, deframes
// 11-bit frames on its falling edges, checks start/stop/odd parity and queues good
// scan codes for the consumer.
//   clock50  : system clock, at least 8x the PS/2 clock
//   clrn     : synchronous active-low reset
//   ps2_clk  : raw PS/2 clock pin (asynchronous)
//   ps2_data : raw PS/2 data pin
//   bus      : consumer handshake (nextdata_n / data / ready / overflow / frame_err)
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic               clock50,
    input  logic               clrn,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_keyboard_rx_if.master  bus
);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             count;
    logic [9:0]             buffer;
    logic                   fall;
    logic                   frame_ok;
    logic                   push;
    logic                   frame_err;

    // Falling event: oldest stage still high, the one behind it already low.
    assign fall = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES-2];

    // Evaluated on the stop-bit event, where ps2_data is the stop bit itself.
    assign frame_ok = (buffer[0] == 1'b0) && ps2_data && (^buffer[9:1]);
    assign push     = fall && (count == STOP_IDX) && frame_ok;

    always_ff @(posedge clock50) begin
        if (!clrn) begin
            sync      <= '1;
            count     <= '0;
            buffer    <= '0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], ps2_clk};
            frame_err <= 1'b0;
            if (fall) begin
                if (count == STOP_IDX) begin
                    count     <= '0;
                    frame_err <= ~frame_ok;
                end else begin
                    buffer[count] <= ps2_data;
                    count         <= count + 1'b1;
                end
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock50   (clock50),
        .clrn      (clrn),
        .push      (push),
        .push_data (buffer[8:1]),
        .pop       (~bus.nextdata_n),
        .head      (bus.data),
        .ready     (bus.ready),
        .overflow  (bus.overflow)
    );

    assign bus.frame_err = frame_err;
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver for the keyboard-input experiments. It runs on the board clock, or on the divided clock from the clock-divider stage, and consumes the raw PS/2 clock and data pins. It deframes each 11-bit PS/2 frame, checks start, stop and odd parity, and queues valid scan codes in a small FIFO. The downstream scan-code state machine pops codes with an active-low `nextdata_n` strobe.

## Interface
- `FIFO_DEPTH`, default 8: scan-code queue depth; must be a power of 2, at least 2.
- `SYNC_STAGES`, default 3: flip-flop stages on `ps2_clk` before edge detection; at least 2.
- `clock50`  in  1: system clock, rising edge. Must run at least 8× the `ps2_clk` frequency (10–16.7 kHz).
- `clrn`  in  1: reset, synchronous, active-low.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1: raw PS/2 data pin.
- `nextdata_n`  in  1: active-low pop request, sampled each rising edge.
- `data`  out  8: FIFO head; valid only while `ready`=1.
- `ready`  out  1: FIFO non-empty.
- `overflow`  out  1: sticky flag; a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1: one-cycle pulse on a start, stop or parity failure.

## Operation
- **Reset.** `clrn`=0 at a rising edge clears:
  - sync chain to all 1s;
  - bit count to 0;
  - shift buffer, FIFO pointers and occupancy;
  - `overflow` and `frame_err`.
  - Reset outputs: `ready`=0, `overflow`=0, `frame_err`=0, `data`=8'h00.
- **Edge detect.** The sync chain shifts `ps2_clk` in each cycle. A falling event is last stage = 1 and previous-to-last stage = 0, lasting exactly one cycle. `ps2_data` is sampled raw on that cycle.
- **Bit count 0..9.** The sampled bit is stored in `buffer[count]` and count increments.
- **Bit count 10 (stop bit).** On this event:
  - Frame is valid iff `buffer[0]`=0, `ps2_data`=1, and XOR of `buffer[9:1]`=1 (odd parity over data plus parity bit).
  - Valid frame: `buffer[8:1]` (LSB first on the wire) is written to the FIFO.
  - Invalid frame: byte discarded, `frame_err`=1 for that single following cycle.
  - Count returns to 0 in every case.
- **Write when full.**
  - If a pop occurs in the same cycle, the write is accepted; occupancy is unchanged.
  - Otherwise the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- **Pop.** `nextdata_n`=0 with `ready`=1 advances the read pointer. `nextdata_n`=0 with `ready`=0 is ignored. `data` is driven combinationally from `fifo[r_ptr]`.
- **Simultaneous push and pop on an empty FIFO.** The push lands; `ready` rises next cycle.
- **Reset mid-frame.** The partial frame and the queue are lost. Any remaining edges of that frame are misparsed. Recovery occurs through `frame_err` on a later frame; no timeout is implemented.

## Timing
- **Edge-detect latency.** Falling edge on the `ps2_clk` pin to detect: `SYNC_STAGES` or `SYNC_STAGES`+1 cycles.
- **Stop-bit edge to `ready`/`data`.** At most `SYNC_STAGES`+2 cycles; 5 with defaults.
- **Pop latency.** Pop at edge N: `data`/`ready` reflect the next entry after edge N. Holding `nextdata_n` low pops one entry per cycle.
- **`frame_err`.** High for exactly one cycle per bad frame.

## Structure
- **Shared package `ps2_pkg`:**
  - `PS2_FRAME_BITS`=11;
  - scan-code constants `SC_BREAK`=8'hF0 and `SC_EXT`=8'hE0, for the downstream decoder.
- **Sub-module `ps2_fifo`.** Synchronous FIFO with width 8, depth `FIFO_DEPTH`, an occupancy counter and push/pop ports. Its full/pop interaction follows the write-when-full rule in Operation.
- **Top level** holds the sync chain, the bit counter/shift buffer and the frame checker.

## Test plan
- **Single frame.** Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) → `ready`=1, `data`=8'h1C within 5 cycles of the stop edge. Hold `nextdata_n`=0 for one cycle → `ready`=0.
- **Ordering.** Frames 0xF0 then 0x1C, no pops → pops return 8'hF0 then 8'h1C, then `ready`=0.
- **Bad parity.** 0x1C sent with parity 1 → `frame_err` high for 1 cycle, `ready` stays 0, `overflow`=0.
- **Overflow.** Frames 0x01..0x09, no pops, depth 8 → `overflow`=1. Pops return 0x01..0x08; 0x09 absent.
- **Full plus pop.** FIFO full, stop edge of 0x2A coincides with a pop → `overflow` stays 0 and 0x2A is the last entry read.
- **Reset recovery.** `clrn`=0 for 2 cycles with 3 bytes queued → `ready`=0. A clean frame 0x1C after release is received correctly.
